// File: rtl/sad_pkg.sv
// Shared types and sizing helpers for the SAD datapath: pixel width,
// default widths, controller state encoding and accumulator sizing.
package sad_pkg;

  localparam int PIX_W     = 8;
  localparam int SAD_W_DEF = 16;
  localparam int IDX_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CMP,
    DONE
  } state_t;

  // Smallest accumulator width that holds 255 * blk_pixels.
  function automatic int sad_w_for(input int blk_pixels);
    return $clog2(255 * blk_pixels + 1);
  endfunction

endpackage

// File: rtl/sad_pe.sv
// One SAD processing element: absolute pixel difference accumulated into a
// register. clr wins over en so a new block can start on the same edge.
module sad_pe
  import sad_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [SAD_W-1:0] acc
);

  logic [PIX_W:0]   diff9;
  logic [PIX_W-1:0] absd;
  logic [SAD_W-1:0] acc_q, acc_d;

  always_comb begin
    diff9 = {1'b0, a} - {1'b0, b};
    // Borrow bit set means b > a: two's-complement negate the low bits.
    absd  = diff9[PIX_W] ? (~diff9[PIX_W-1:0] + 8'd1) : diff9[PIX_W-1:0];
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + SAD_W'(absd);
  end

  always_ff @(posedge clk) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/sad_block_accumulator.sv
// Full-search SAD controller: pulls BLK_PIXELS pixel pairs per candidate
// from two FIFOs, reports each candidate SAD and tracks the minimum.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads for the current candidate
// DRAIN | last pixel pair accumulating
// CMP   | SAD complete: report it and update the best
// DONE  | search finished, done pulse
module sad_block_accumulator
  import sad_pkg::*;
#(
  parameter int BLK_PIXELS = 256,
  parameter int NUM_CAND   = 289,
  parameter int SAD_W      = sad_w_for(BLK_PIXELS),
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8:0]       cur_count,
  input  logic [8:0]       ref_count,
  input  logic [PIX_W-1:0] cur_data,
  input  logic [PIX_W-1:0] ref_data,
  output logic             cur_rd,
  output logic             ref_rd,
  output logic             busy,
  output logic             sad_valid,
  output logic [SAD_W-1:0] sad,
  output logic [IDX_W-1:0] cand_idx,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  localparam int CNT_W = $clog2(BLK_PIXELS + 1);
  localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLK_PIXELS);
  localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NUM_CAND - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SAD_W-1:0] best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             rd_q, rd_d, rd_d1_q;
  logic             busy_q, sad_valid_q, done_q;
  logic             acc_clr, cur_avail, ref_avail;
  logic [SAD_W-1:0] acc;

  always_comb begin
    state_d    = state_q;
    iss_d      = iss_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    acc_clr    = 1'b0;
    // The read strobe is registered, so the read already on the bus has not
    // yet left the FIFO count; it must not be counted as available again.
    cur_avail  = rd_q ? (cur_count > 9'd1) : (cur_count != 9'd0);
    ref_avail  = rd_q ? (ref_count > 9'd1) : (ref_count != 9'd0);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          iss_d   = '0;
          idx_d   = '0;
          acc_clr = 1'b1;
        end
      end
      RUN: begin
        if (iss_q == BLK_LAST) state_d = DRAIN;
      end
      DRAIN: state_d = CMP;
      CMP: begin
        if ((idx_q == '0) || (acc < best_q)) begin
          best_d     = acc;
          best_idx_d = idx_q;
        end
        if (idx_q == CAND_LAST) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          iss_d   = '0;
          idx_d   = idx_q + 1'b1;
          acc_clr = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_d = (state_d == RUN) && (iss_d != BLK_LAST) && cur_avail && ref_avail;
    if (rd_d) iss_d = iss_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      iss_q       <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      rd_q        <= 1'b0;
      rd_d1_q     <= 1'b0;
      busy_q      <= 1'b0;
      sad_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      rd_q        <= rd_d;
      rd_d1_q     <= rd_q;
      busy_q      <= (state_d == RUN) || (state_d == DRAIN) || (state_d == CMP);
      sad_valid_q <= (state_d == CMP);
      done_q      <= (state_d == DONE);
    end
  end

  sad_pe #(
    .SAD_W(SAD_W)
  ) u_pe (
    .clk(clk),
    .rst(rst),
    .clr(acc_clr),
    .en (rd_d1_q),
    .a  (cur_data),
    .b  (ref_data),
    .acc(acc)
  );

  assign cur_rd    = rd_q;
  assign ref_rd    = rd_q;
  assign busy      = busy_q;
  assign sad_valid = sad_valid_q;
  assign sad       = acc;
  assign cand_idx  = idx_q;
  assign done      = done_q;
  assign best_sad  = best_q;
  assign best_idx  = best_idx_q;

endmodule
